// File: rtl/sparse_tok_pkg.sv
// Shared token definitions and decode helpers for the sparse coordinate stream blocks.
package sparse_tok_pkg;

  localparam int TOK_W    = 17;
  localparam int CTRL_BIT = 16;

  typedef logic [TOK_W-1:0] tok_t;

  localparam tok_t DONE_TOKEN = 17'h10100;

  typedef enum logic [1:0] {
    GET_OUTER,
    SCAN_INNER,
    WAIT_DONE
  } crd_drop_state_t;

  function automatic logic is_ctrl(input tok_t t);
    return t[CTRL_BIT];
  endfunction

  function automatic logic is_done(input tok_t t);
    return t[CTRL_BIT] && (t[9:8] == 2'b01);
  endfunction

  function automatic logic is_stop(input tok_t t);
    return t[CTRL_BIT] && (t[9:8] == 2'b00);
  endfunction

  function automatic logic [7:0] stop_lvl(input tok_t t);
    return t[7:0];
  endfunction

endpackage

// File: rtl/tok_fifo2.sv
// Two-entry valid/ready register FIFO; push and pop may coincide even when full.
module tok_fifo2 #(
  parameter int DEPTH = 2,
  parameter int W     = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         clk_en,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_space,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic [W-1:0] r_mem [2];
  logic         r_wrPtr;
  logic         r_rdPtr;
  logic [1:0]   r_count;

  logic w_full;
  logic w_pop;
  logic w_push;

  always_comb begin
    w_full  = (r_count == 2'(DEPTH));
    o_valid = (r_count != 2'd0);
    o_data  = r_mem[r_rdPtr];
    w_pop   = o_valid && i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    o_space = !w_full || w_pop;
    w_push  = i_push && o_space;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= 2'd0;
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
    end else if (clk_en) begin
      if (w_push) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

// File: rtl/crd_drop.sv
// Drops outer coordinates whose inner fiber is empty; the inner stream passes through untouched.
module crd_drop #(
  parameter int TOK_W  = 17,
  parameter int FIFO_D = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             tile_en,
  input  logic [TOK_W-1:0] outer_in,
  input  logic             outer_in_valid,
  output logic             outer_in_ready,
  input  logic [TOK_W-1:0] inner_in,
  input  logic             inner_in_valid,
  output logic             inner_in_ready,
  output logic [TOK_W-1:0] outer_out,
  output logic             outer_out_valid,
  input  logic             outer_out_ready,
  output logic [TOK_W-1:0] inner_out,
  output logic             inner_out_valid,
  input  logic             inner_out_ready,
  output logic             err
);

  import sparse_tok_pkg::*;

  crd_drop_state_t r_state;
  crd_drop_state_t w_nextState;
  tok_t            r_holdCrd;
  logic            r_seen;
  logic            r_err;

  logic w_clr;
  logic w_outerSpace, w_innerSpace;
  logic w_outerRdy, w_innerRdy;
  logic w_outerFire, w_innerFire;
  logic w_pushOuter, w_pushInner;
  tok_t w_outerPushData, w_innerPushData;
  logic w_latchHold, w_setSeen, w_setErr;
  logic w_outerFifoValid, w_innerFifoValid;
  tok_t w_outerFifoData, w_innerFifoData;

  assign w_clr = rst || flush;

  // Readiness depends on the pending inner token: closing a fiber may need both FIFOs.
  always_comb begin
    w_outerRdy = 1'b0;
    w_innerRdy = 1'b0;
    unique case (r_state)
      GET_OUTER: w_outerRdy = w_outerSpace;
      SCAN_INNER: begin
        if (inner_in_valid && (is_done(inner_in) || (is_stop(inner_in) && r_seen)))
          w_innerRdy = w_outerSpace && w_innerSpace;
        else
          w_innerRdy = w_innerSpace;
      end
      WAIT_DONE: begin
        if (inner_in_valid && is_done(inner_in))
          w_innerRdy = w_outerSpace && w_innerSpace;
        else
          w_innerRdy = w_innerSpace;
      end
      default: ;
    endcase
    outer_in_ready = w_outerRdy && tile_en && !w_clr;
    inner_in_ready = w_innerRdy && tile_en && !w_clr;
    w_outerFire    = outer_in_valid && outer_in_ready && clk_en;
    w_innerFire    = inner_in_valid && inner_in_ready && clk_en;
  end

  always_comb begin
    w_nextState     = r_state;
    w_pushOuter     = 1'b0;
    w_pushInner     = 1'b0;
    w_outerPushData = outer_in;
    w_innerPushData = inner_in;
    w_latchHold     = 1'b0;
    w_setSeen       = 1'b0;
    w_setErr        = 1'b0;
    unique case (r_state)
      GET_OUTER: begin
        if (w_outerFire) begin
          if (!is_ctrl(outer_in)) begin
            w_latchHold = 1'b1;
            w_nextState = SCAN_INNER;
          end else if (is_stop(outer_in)) begin
            w_pushOuter = 1'b1;
          end else if (is_done(outer_in)) begin
            w_nextState = WAIT_DONE;
          end else begin
            w_setErr = 1'b1;
          end
        end
      end
      SCAN_INNER: begin
        if (w_innerFire) begin
          if (!is_ctrl(inner_in)) begin
            w_pushInner = 1'b1;
            w_setSeen   = 1'b1;
          end else if (is_stop(inner_in)) begin
            w_pushInner     = 1'b1;
            w_pushOuter     = r_seen;
            w_outerPushData = r_holdCrd;
            w_nextState     = GET_OUTER;
          end else if (is_done(inner_in)) begin
            w_setErr        = 1'b1;
            w_pushInner     = 1'b1;
            w_pushOuter     = 1'b1;
            w_outerPushData = DONE_TOKEN;
            w_innerPushData = DONE_TOKEN;
            w_nextState     = GET_OUTER;
          end else begin
            w_setErr = 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (w_innerFire) begin
          if (is_done(inner_in)) begin
            w_pushInner     = 1'b1;
            w_pushOuter     = 1'b1;
            w_outerPushData = DONE_TOKEN;
            w_innerPushData = DONE_TOKEN;
            w_nextState     = GET_OUTER;
          end else if (is_ctrl(inner_in) && !is_stop(inner_in)) begin
            w_setErr = 1'b1;
          end else begin
            w_pushInner = 1'b1;
          end
        end
      end
      default: w_nextState = GET_OUTER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state   <= GET_OUTER;
      r_holdCrd <= '0;
      r_seen    <= 1'b0;
      r_err     <= 1'b0;
    end else if (clk_en) begin
      r_state <= w_nextState;
      if (w_latchHold) begin
        r_holdCrd <= outer_in;
        r_seen    <= 1'b0;
      end else if (w_setSeen) begin
        r_seen <= 1'b1;
      end
      if (w_setErr) begin
        r_err <= 1'b1;
      end
    end
  end

  tok_fifo2 #(.DEPTH(FIFO_D), .W(TOK_W)) u_outerFifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .clk_en  (clk_en),
    .i_push  (w_pushOuter),
    .i_data  (w_outerPushData),
    .o_space (w_outerSpace),
    .o_valid (w_outerFifoValid),
    .o_data  (w_outerFifoData),
    .i_ready (outer_out_ready && tile_en && !w_clr)
  );

  tok_fifo2 #(.DEPTH(FIFO_D), .W(TOK_W)) u_innerFifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .clk_en  (clk_en),
    .i_push  (w_pushInner),
    .i_data  (w_innerPushData),
    .o_space (w_innerSpace),
    .o_valid (w_innerFifoValid),
    .o_data  (w_innerFifoData),
    .i_ready (inner_out_ready && tile_en && !w_clr)
  );

  assign outer_out       = w_outerFifoData;
  assign inner_out       = w_innerFifoData;
  assign outer_out_valid = w_outerFifoValid && tile_en && !w_clr;
  assign inner_out_valid = w_innerFifoValid && tile_en && !w_clr;
  assign err             = r_err;

endmodule

// File: tb/tb_crd_drop.sv
// Self-checking bench for crd_drop: table of tile streams plus hand-written reset/enable sequences.
module tb_crd_drop;

  import sparse_tok_pkg::*;

  localparam tok_t DN = DONE_TOKEN;
  localparam tok_t S0 = 17'h10000;
  localparam tok_t S1 = 17'h10001;

  logic clk = 1'b0;
  logic rst, clk_en, flush, tile_en;
  tok_t outer_in, inner_in, outer_out, inner_out;
  logic outer_in_valid, outer_in_ready, inner_in_valid, inner_in_ready;
  logic outer_out_valid, outer_out_ready, inner_out_valid, inner_out_ready;
  logic err;

  always #5 clk = ~clk;

  crd_drop dut (
    .clk             (clk),
    .rst             (rst),
    .clk_en          (clk_en),
    .flush           (flush),
    .tile_en         (tile_en),
    .outer_in        (outer_in),
    .outer_in_valid  (outer_in_valid),
    .outer_in_ready  (outer_in_ready),
    .inner_in        (inner_in),
    .inner_in_valid  (inner_in_valid),
    .inner_in_ready  (inner_in_ready),
    .outer_out       (outer_out),
    .outer_out_valid (outer_out_valid),
    .outer_out_ready (outer_out_ready),
    .inner_out       (inner_out),
    .inner_out_valid (inner_out_valid),
    .inner_out_ready (inner_out_ready),
    .err             (err)
  );

  typedef struct {
    int   nO;
    int   nI;
    int   nEO;
    int   nEI;
    tok_t o[12];
    tok_t i[12];
    tok_t eo[12];
    tok_t ei[12];
    logic expErr;
    logic bp;
  } case_t;

  case_t cases[5];
  int    nCases = 0;
  tok_t  qO[$], qI[$], qEO[$], qEI[$];
  tok_t  rxO[$], rxI[$];
  int    errors = 0;
  int    checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addCase(input logic e, input logic bp);
    case_t c;
    c.nO  = qO.size();
    c.nI  = qI.size();
    c.nEO = qEO.size();
    c.nEI = qEI.size();
    for (int n = 0; n < 12; n++) begin
      c.o[n]  = (n < c.nO)  ? qO[n]  : '0;
      c.i[n]  = (n < c.nI)  ? qI[n]  : '0;
      c.eo[n] = (n < c.nEO) ? qEO[n] : '0;
      c.ei[n] = (n < c.nEI) ? qEI[n] : '0;
    end
    c.expErr = e;
    c.bp     = bp;
    cases[nCases] = c;
    nCases++;
  endtask

  task automatic resetDut(input bit doChecks);
    @(negedge clk);
    rst = 1'b1;
    outer_in_valid = 1'b0;
    inner_in_valid = 1'b0;
    #4;
    if (doChecks) begin
      checkOutput("rstOuterInReady", 32'(outer_in_ready), 32'd0);
      checkOutput("rstInnerInReady", 32'(inner_in_ready), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #4;
    if (doChecks) begin
      checkOutput("postRstOuterValid", 32'(outer_out_valid), 32'd0);
      checkOutput("postRstInnerValid", 32'(inner_out_valid), 32'd0);
      checkOutput("postRstErr", 32'(err), 32'd0);
      checkOutput("postRstOuterReady", 32'(outer_in_ready), 32'd1);
      checkOutput("postRstInnerReady", 32'(inner_in_ready), 32'd0);
    end
  endtask

  task automatic driveOuter(input int k);
    int   idx = 0;
    int   cyc = 0;
    logic fire;
    while (idx < cases[k].nO && cyc < 400) begin
      @(negedge clk);
      outer_in       = cases[k].o[idx];
      outer_in_valid = 1'b1;
      #4;
      fire = outer_in_ready;
      if (fire) idx++;
      cyc++;
    end
    @(negedge clk);
    outer_in_valid = 1'b0;
    checkOutput($sformatf("case%0d outerDriven", k), 32'(idx), 32'(cases[k].nO));
  endtask

  task automatic driveInner(input int k);
    int   idx = 0;
    int   cyc = 0;
    logic fire;
    while (idx < cases[k].nI && cyc < 400) begin
      @(negedge clk);
      inner_in       = cases[k].i[idx];
      inner_in_valid = 1'b1;
      #4;
      fire = inner_in_ready;
      if (fire) idx++;
      cyc++;
    end
    @(negedge clk);
    inner_in_valid = 1'b0;
    checkOutput($sformatf("case%0d innerDriven", k), 32'(idx), 32'(cases[k].nI));
  endtask

  // Sinks both outputs, optionally with random stalls, and checks held tokens stay put.
  task automatic collect(input int k);
    int   cyc  = 0;
    int   tail = 0;
    logic hO = 1'b0, hI = 1'b0;
    tok_t pO = '0, pI = '0;
    while (cyc < 400 && tail < 4) begin
      @(negedge clk);
      outer_out_ready = cases[k].bp ? 1'($urandom_range(0, 1)) : 1'b1;
      inner_out_ready = cases[k].bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      if (hO) begin
        checkOutput("outerStableValid", 32'(outer_out_valid), 32'd1);
        checkOutput("outerStableData", 32'(outer_out), 32'(pO));
      end
      if (hI) begin
        checkOutput("innerStableValid", 32'(inner_out_valid), 32'd1);
        checkOutput("innerStableData", 32'(inner_out), 32'(pI));
      end
      if (outer_out_valid && outer_out_ready) rxO.push_back(outer_out);
      if (inner_out_valid && inner_out_ready) rxI.push_back(inner_out);
      hO = outer_out_valid && !outer_out_ready;
      hI = inner_out_valid && !inner_out_ready;
      pO = outer_out;
      pI = inner_out;
      if (rxO.size() >= cases[k].nEO && rxI.size() >= cases[k].nEI) tail++;
      cyc++;
    end
    @(negedge clk);
    outer_out_ready = 1'b0;
    inner_out_ready = 1'b0;
    checkOutput($sformatf("case%0d collectDone", k), 32'(tail >= 4), 32'd1);
  endtask

  task automatic applyStimulus(input int k, input bit doReset);
    if (doReset) resetDut(1'b0);
    rxO.delete();
    rxI.delete();
    fork
      driveOuter(k);
      driveInner(k);
      collect(k);
    join
    checkOutput($sformatf("case%0d outerCount", k), 32'(rxO.size()), 32'(cases[k].nEO));
    checkOutput($sformatf("case%0d innerCount", k), 32'(rxI.size()), 32'(cases[k].nEI));
    for (int n = 0; n < cases[k].nEO && n < rxO.size(); n++)
      checkOutput($sformatf("case%0d outer[%0d]", k, n), 32'(rxO[n]), 32'(cases[k].eo[n]));
    for (int n = 0; n < cases[k].nEI && n < rxI.size(); n++)
      checkOutput($sformatf("case%0d inner[%0d]", k, n), 32'(rxI[n]), 32'(cases[k].ei[n]));
    checkOutput($sformatf("case%0d err", k), 32'(err), 32'(cases[k].expErr));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clk_en = 1'b1; tile_en = 1'b1;
    outer_in = '0; inner_in = '0;
    outer_in_valid = 1'b0; inner_in_valid = 1'b0;
    outer_out_ready = 1'b0; inner_out_ready = 1'b0;

    // Tile A: coordinate 7 has an empty fiber.
    qO = '{17'd5, 17'd7, S0, DN};          qI = '{17'd1, S0, S1, DN};
    qEO = '{17'd5, S0, DN};                qEI = '{17'd1, S0, S1, DN};
    addCase(1'b0, 1'b0);
    // Tile B: coordinates 2 and 4 have empty fibers.
    qO = '{17'd2, 17'd3, 17'd4, S0, DN};   qI = '{S0, 17'd9, S0, S1, DN};
    qEO = '{17'd3, S0, DN};                qEI = '{S0, 17'd9, S0, S1, DN};
    addCase(1'b0, 1'b0);
    // Tile A again under random back-pressure.
    qO = '{17'd5, 17'd7, S0, DN};          qI = '{17'd1, S0, S1, DN};
    qEO = '{17'd5, S0, DN};                qEI = '{17'd1, S0, S1, DN};
    addCase(1'b0, 1'b1);
    // Tiles A then B back to back.
    qO = '{17'd5, 17'd7, S0, DN, 17'd2, 17'd3, 17'd4, S0, DN};
    qI = '{17'd1, S0, S1, DN, S0, 17'd9, S0, S1, DN};
    qEO = '{17'd5, S0, DN, 17'd3, S0, DN};
    qEI = '{17'd1, S0, S1, DN, S0, 17'd9, S0, S1, DN};
    addCase(1'b0, 1'b0);
    // Inner DONE while holding 6: protocol error, 6 is discarded.
    qO = '{17'd6};                         qI = '{DN};
    qEO = '{DN};                           qEI = '{DN};
    addCase(1'b1, 1'b0);

    resetDut(1'b1);

    @(negedge clk);
    tile_en = 1'b0;
    outer_in = 17'd5;
    outer_in_valid = 1'b1;
    #4;
    checkOutput("tileOffOuterReady", 32'(outer_in_ready), 32'd0);
    @(negedge clk);
    outer_in_valid = 1'b0;
    tile_en = 1'b1;
    #4;
    checkOutput("tileOffNoAcceptInner", 32'(inner_in_ready), 32'd0);
    checkOutput("tileOffNoAcceptOuter", 32'(outer_in_ready), 32'd1);

    for (int k = 0; k < nCases; k++) applyStimulus(k, 1'b1);

    // err is set from the last case; park in SCAN_INNER holding 8, then reset.
    @(negedge clk);
    outer_in = 17'd8;
    outer_in_valid = 1'b1;
    #4;
    checkOutput("holdAccept", 32'(outer_in_ready), 32'd1);
    @(negedge clk);
    outer_in_valid = 1'b0;
    #4;
    checkOutput("scanOuterReady", 32'(outer_in_ready), 32'd0);
    checkOutput("scanInnerReady", 32'(inner_in_ready), 32'd1);
    resetDut(1'b1);
    applyStimulus(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
